// File: rtl/wta_pkg.sv
// Shared types and widths for the winner-take-all scheduler.
package wta_pkg;

    localparam int CNT_W = 8;
    localparam int MEM_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UPDATE,
        S_INHIBIT,
        S_SELECT,
        S_DONE
    } state_t;

    // Neuron index width; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wta_lif_update.sv
// Shared LIF datapath: leak, saturating integrate, threshold and reset-by-subtraction.
module wta_lif_update
    import wta_pkg::*;
#(
    parameter int THRESHOLD  = 200,
    parameter int LEAK_SHIFT = 1
) (
    input  logic [MEM_W-1:0] mem,
    input  logic [MEM_W-1:0] cur,
    output logic [MEM_W-1:0] mem_next,
    output logic             spike
);

    logic [MEM_W-1:0] kept;
    logic [MEM_W:0]   sum;
    logic [MEM_W-1:0] sat;

    // Leaked membrane plus input current, clamped to full scale before the threshold test.
    always_comb begin
        kept     = mem - (mem >> LEAK_SHIFT);
        sum      = {1'b0, cur} + {1'b0, kept};
        sat      = sum[MEM_W] ? {MEM_W{1'b1}} : sum[MEM_W-1:0];
        spike    = (sat >= MEM_W'(THRESHOLD));
        mem_next = spike ? (sat - MEM_W'(THRESHOLD)) : sat;
    end

endmodule

// File: rtl/wta_sched.sv
// Time-multiplexed WTA scheduler: loads currents, steps all neurons through one
// shared LIF datapath per timestep, applies lateral inhibition, then picks the
// neuron with the most spikes over the window.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | accepting one current per neuron over the valid/ready handshake
// UPDATE  | one neuron per cycle through the LIF datapath
// INHIBIT | publish step spikes, clear losers' membranes, advance timestep
// SELECT  | argmax over spike counts, one neuron per cycle
// DONE    | pulse done with winner and no_spike valid
module wta_sched
    import wta_pkg::*;
#(
    parameter int N_NEURONS  = 4,
    parameter int THRESHOLD  = 200,
    parameter int LEAK_SHIFT = 1,
    parameter int WINDOW     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [7:0]                    cur_in,
    input  logic                          cur_valid,
    output logic                          cur_ready,
    output logic                          busy,
    output logic [N_NEURONS-1:0]          step_spikes,
    output logic                          step_valid,
    output logic [idx_w(N_NEURONS)-1:0]   winner,
    output logic                          no_spike,
    output logic                          done
);

    localparam int               IDX_W    = idx_w(N_NEURONS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURONS - 1);

    state_t               state, state_nx;
    logic [IDX_W-1:0]     idx;
    logic [MEM_W-1:0]     cur_q [N_NEURONS];
    logic [MEM_W-1:0]     mem_q [N_NEURONS];
    logic [CNT_W-1:0]     cnt_q [N_NEURONS];
    logic [N_NEURONS-1:0] step_bits;
    logic [7:0]           tstep;
    logic [CNT_W-1:0]     best_cnt;
    logic [IDX_W-1:0]     best_idx;

    logic [MEM_W-1:0]     mem_next;
    logic                 spike;
    logic                 last_step;
    logic                 any_spike;
    logic [IDX_W-1:0]     step_win;
    logic                 sel_take;

    assign last_step = ((tstep + 8'd1) == 8'(WINDOW));
    assign sel_take  = (cnt_q[idx] > best_cnt);

    wta_lif_update #(
        .THRESHOLD  (THRESHOLD),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lif (
        .mem      (mem_q[idx]),
        .cur      (cur_q[idx]),
        .mem_next (mem_next),
        .spike    (spike)
    );

    // Lowest-index spiking neuron of the current step wins the inhibition.
    always_comb begin
        any_spike = |step_bits;
        step_win  = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (step_bits[i]) step_win = IDX_W'(i);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nx    = state;
        cur_ready   = 1'b0;
        busy        = 1'b1;
        step_valid  = 1'b0;
        step_spikes = '0;
        done        = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                cur_ready = 1'b1;
                if (cur_valid && idx == IDX_LAST) state_nx = S_UPDATE;
            end
            S_UPDATE: begin
                if (idx == IDX_LAST) state_nx = S_INHIBIT;
            end
            S_INHIBIT: begin
                step_valid  = 1'b1;
                step_spikes = step_bits;
                state_nx    = last_step ? S_SELECT : S_UPDATE;
            end
            S_SELECT: begin
                if (idx == IDX_LAST) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Register arrays, counters and the argmax; idx wraps because N is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            tstep     <= '0;
            step_bits <= '0;
            best_cnt  <= '0;
            best_idx  <= '0;
            winner    <= '0;
            no_spike  <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                cur_q[i] <= '0;
                mem_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        tstep     <= '0;
                        step_bits <= '0;
                        best_cnt  <= '0;
                        best_idx  <= '0;
                        winner    <= '0;
                        no_spike  <= 1'b0;
                        for (int i = 0; i < N_NEURONS; i++) begin
                            mem_q[i] <= '0;
                            cnt_q[i] <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    if (cur_valid) begin
                        cur_q[idx] <= cur_in;
                        idx        <= idx + 1'b1;
                    end
                end
                S_UPDATE: begin
                    mem_q[idx] <= mem_next;
                    if (spike) begin
                        step_bits[idx] <= 1'b1;
                        if (cnt_q[idx] != '1) cnt_q[idx] <= cnt_q[idx] + 1'b1;
                    end
                    idx <= idx + 1'b1;
                end
                S_INHIBIT: begin
                    for (int i = 0; i < N_NEURONS; i++) begin
                        if (any_spike && IDX_W'(i) != step_win) mem_q[i] <= '0;
                    end
                    step_bits <= '0;
                    tstep     <= tstep + 8'd1;
                    idx       <= '0;
                end
                S_SELECT: begin
                    if (sel_take) begin
                        best_cnt <= cnt_q[idx];
                        best_idx <= idx;
                    end
                    // Final compare lands directly in the outputs so they are valid during DONE.
                    if (idx == IDX_LAST) begin
                        winner   <= sel_take ? idx : best_idx;
                        no_spike <= ((sel_take ? cnt_q[idx] : best_cnt) == '0);
                    end
                    idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wta_sched.sv
module tb_wta_sched;

    localparam int N      = 4;
    localparam int WIN    = 16;
    localparam int THR    = 200;
    localparam int DONE_AT = 85;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cur_in = '0;
    logic       cur_valid = 1'b0;
    logic       cur_ready;
    logic       busy;
    logic [3:0] step_spikes;
    logic       step_valid;
    logic [1:0] winner;
    logic       no_spike;
    logic       done;

    wta_sched #(
        .N_NEURONS (N),
        .THRESHOLD (THR),
        .LEAK_SHIFT(1),
        .WINDOW    (WIN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cur_in     (cur_in),
        .cur_valid  (cur_valid),
        .cur_ready  (cur_ready),
        .busy       (busy),
        .step_spikes(step_spikes),
        .step_valid (step_valid),
        .winner     (winner),
        .no_spike   (no_spike),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][7:0] cur;
        logic            gap;
        logic            glitch;
        logic [1:0]      exp_winner;
        logic            exp_no_spike;
        int              exp_first_step;
        logic [3:0]      exp_first_mask;
    } vec_t;

    typedef struct {
        logic [1:0] w;
        logic       ns;
    } fin_t;

    int         n_checks = 0;
    int         n_fail = 0;
    int         step_no = 0;
    int         first_step = 0;
    logic [3:0] first_mask = '0;
    int         done_seen = 0;
    logic [3:0] exp_masks[$];
    fin_t       exp_final[$];
    vec_t       vecs[8];

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [3:0][7:0] cv(input int c0, input int c1, input int c2, input int c3);
        logic [3:0][7:0] r;
        r[0] = 8'(c0); r[1] = 8'(c1); r[2] = 8'(c2); r[3] = 8'(c3);
        return r;
    endfunction

    // Reference LIF network: pushes the expected per-step spike masks.
    function automatic void push_model(input logic [3:0][7:0] c);
        int m[4];
        for (int n = 0; n < N; n++) m[n] = 0;
        for (int t = 0; t < WIN; t++) begin
            logic [3:0] mk;
            int         w;
            mk = '0;
            for (int n = 0; n < N; n++) begin
                int s;
                s = int'(c[n]) + m[n] - m[n] / 2;
                if (s > 255) s = 255;
                if (s >= THR) begin
                    m[n]  = s - THR;
                    mk[n] = 1'b1;
                end else begin
                    m[n] = s;
                end
            end
            if (mk != 0) begin
                w = 0;
                for (int n = N - 1; n >= 0; n--) if (mk[n]) w = n;
                for (int n = 0; n < N; n++) if (n != w) m[n] = 0;
            end
            exp_masks.push_back(mk);
        end
    endfunction

    // Output monitor: pops the scoreboard on each step_valid and done pulse.
    always @(negedge clk) begin
        if (rst_n && step_valid) begin
            step_no++;
            if (first_step == 0 && step_spikes != 0) begin
                first_step = step_no;
                first_mask = step_spikes;
            end
            if (exp_masks.size() == 0) begin
                check("step_unexpected", 1, 0);
            end else begin
                logic [3:0] e;
                e = exp_masks.pop_front();
                check($sformatf("step_spikes[t%0d]", step_no), int'(step_spikes), int'(e));
            end
        end
        if (rst_n && done) begin
            done_seen++;
            if (exp_final.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                fin_t f;
                f = exp_final.pop_front();
                check("winner", int'(winner), int'(f.w));
                check("no_spike", int'(no_spike), int'(f.ns));
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        step_no    = 0;
        first_step = 0;
        first_mask = '0;
        check("busy_after_start", int'(busy), 1);
        check("ready_in_load", int'(cur_ready), 1);
    endtask

    // Loads all currents; returns at the negedge right after the last transfer edge (cycle 1).
    task automatic load(input logic [3:0][7:0] c, input logic gap);
        for (int i = 0; i < N; i++) begin
            if (gap && i == 2) begin
                cur_valid = 1'b0;
                cur_in    = 8'hEE;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("ready_held_gap", int'(cur_ready), 1);
                end
            end
            cur_in    = c[i];
            cur_valid = 1'b1;
            @(negedge clk);
        end
        cur_valid = 1'b0;
        cur_in    = 8'h00;
    endtask

    task automatic run_case(input vec_t v, input int id);
        fin_t f;
        int   cyc;
        do_start();
        push_model(v.cur);
        f.w  = v.exp_winner;
        f.ns = v.exp_no_spike;
        exp_final.push_back(f);
        load(v.cur, v.gap);
        cyc = 1;
        check($sformatf("ready_low_after_load[%0d]", id), int'(cur_ready), 0);
        while (!done && cyc < 200) begin
            if (v.glitch && cyc == 3) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        check($sformatf("done_cycle[%0d]", id), cyc, DONE_AT);
        check($sformatf("first_spike_step[%0d]", id), first_step, v.exp_first_step);
        check($sformatf("first_spike_mask[%0d]", id), int'(first_mask), int'(v.exp_first_mask));
        @(negedge clk);
        check($sformatf("busy_fall[%0d]", id), int'(busy), 0);
        check($sformatf("winner_held[%0d]", id), int'(winner), int'(v.exp_winner));
        check($sformatf("no_spike_held[%0d]", id), int'(no_spike), int'(v.exp_no_spike));
    endtask

    initial begin
        vecs[0] = '{cv(120, 0, 0, 0),     1'b0, 1'b0, 2'd0, 1'b0, 3, 4'b0001};
        vecs[1] = '{cv(0, 0, 0, 0),       1'b0, 1'b0, 2'd0, 1'b1, 0, 4'b0000};
        vecs[2] = '{cv(0, 0, 150, 150),   1'b0, 1'b0, 2'd2, 1'b0, 2, 4'b1100};
        vecs[3] = '{cv(255, 255, 255, 255), 1'b0, 1'b0, 2'd0, 1'b0, 1, 4'b1111};
        vecs[4] = '{cv(120, 0, 0, 0),     1'b1, 1'b1, 2'd0, 1'b0, 3, 4'b0001};
        vecs[5] = '{cv(0, 200, 0, 0),     1'b0, 1'b0, 2'd1, 1'b0, 1, 4'b0010};
        vecs[6] = '{cv(10, 20, 30, 40),   1'b0, 1'b0, 2'd0, 1'b1, 0, 4'b0000};
        vecs[7] = '{cv(0, 0, 0, 199),     1'b0, 1'b0, 2'd3, 1'b0, 2, 4'b1000};

        repeat (3) @(negedge clk);
        check("rst_cur_ready", int'(cur_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_step_valid", int'(step_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_no_spike", int'(no_spike), 0);
        check("rst_step_spikes", int'(step_spikes), 0);
        check("rst_winner", int'(winner), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_case(vecs[i], i);

        // Asynchronous reset in the middle of UPDATE aborts the inference.
        do_start();
        push_model(vecs[0].cur);
        load(vecs[0].cur, 1'b0);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_step_valid", int'(step_valid), 0);
        exp_masks.delete();
        exp_final.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_done", int'(done), 0);
        end
        rst_n = 1'b1;
        run_case(vecs[0], 8);

        check("done_count", done_seen, 9);
        check("masks_drained", exp_masks.size(), 0);
        check("finals_drained", exp_final.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wta_sched.md
# wta_sched

Time-multiplexed scheduler for the winner-take-all network. It owns one shared LIF update datapath and sequences it across `N_NEURONS` membrane registers over a fixed inference window. It applies lateral inhibition after every timestep and reports the neuron with the most spikes. It sits between the `ui_in` input path (per-neuron currents loaded serially) and `uo_out` (winner and status).

## Interface
- `N_NEURONS`, default 4: neuron count; power of two, 2–8.
- `THRESHOLD`, default 200: spike threshold, 8-bit.
- `LEAK_SHIFT`, default 1: leak is `mem >> LEAK_SHIFT` per timestep.
- `WINDOW`, default 16: timesteps per inference, 1–255.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin inference; sampled only in IDLE.
- `cur_in`  in  8  current for the neuron being loaded.
- `cur_valid`  in  1  `cur_in` valid.
- `cur_ready`  out  1  high in LOAD; a transfer occurs when valid and ready are both high.
- `busy`  out  1  high in every state except IDLE.
- `step_spikes`  out  N_NEURONS  spikes of the just-finished timestep; valid when `step_valid` is high.
- `step_valid`  out  1  one-cycle pulse in INHIBIT.
- `winner`  out  log2(N)  winning index; held until the next `start`.
- `no_spike`  out  1  set with `done` if no neuron spiked in the window.
- `done`  out  1  one-cycle pulse in DONE.

## Operation
- States: IDLE → LOAD → UPDATE ⇄ INHIBIT → SELECT → DONE → IDLE.
- IDLE: all membranes, spike counts and the timestep counter are cleared on `start`. `start` is ignored in other states.
- LOAD: `cur[idx] <= cur_in` on each transfer; idx runs 0..N-1. Idle cycles are allowed when `cur_valid` is low. After transfer N-1, go to UPDATE with idx=0.
- UPDATE: one neuron per cycle, idx 0..N-1.
  - `s = cur[idx] + (mem[idx] - (mem[idx] >> LEAK_SHIFT))`, computed 9-bit and saturated to 255.
  - If `s >= THRESHOLD`: `mem <= s - THRESHOLD`, set the step spike bit, and increment `cnt[idx]`. `cnt` is 8-bit and saturates at 255.
  - Otherwise `mem <= s`.
  - After idx N-1, go to INHIBIT.
- INHIBIT (1 cycle):
  - Drive `step_spikes` and pulse `step_valid`.
  - If any bit is set, the lowest set index is the step winner; clear `mem` of every other neuron. Spikes already counted this step stay counted.
  - Clear the step bits and increment the timestep counter.
  - If counter == WINDOW, go to SELECT; else go to UPDATE with idx=0.
- SELECT: scan `cnt[0..N-1]`, one per cycle. Replace the best only on strictly greater, so ties go to the lowest index.
- DONE (1 cycle): pulse `done`, update `winner`, set `no_spike` = (best count == 0). `winner` = 0 when `no_spike` is set. Go to IDLE.
- Reset mid-operation: all state is cleared immediately and the FSM returns to IDLE; no `done` is produced.

## Timing
- Reset values: `cur_ready`, `busy`, `step_valid`, `done`, `no_spike` = 0; `step_spikes` = 0; `winner` = 0.
- `busy` rises the cycle after `start` is sampled. LOAD takes N cycles minimum.
- Each timestep takes N+1 cycles.
- `done` is asserted in cycle WINDOW·(N+1)+N+1 after the last load transfer edge. Defaults: 85.
- `busy` falls the cycle after `done`. A new `start` can be accepted that same cycle.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs except `cur_ready`, which is from state.

## Structure
- `wta_pkg`: state enum, `CNT_W` = 8, `MEM_W` = 8, and the `clog2`-derived index width.
- Sub-module `wta_lif_update`: the combinational shared datapath.
  - Inputs: mem, cur.
  - Outputs: mem_next, spike.
  - Implements the leak, the saturating add and the threshold subtract. It is instantiated once.
- The FSM, register arrays and SELECT argmax stay in `wta_sched`.

## Test plan
- Currents {120,0,0,0}, defaults:
  - neuron 0 membrane goes 120, 180, 210 → spike at step 3 (mem 10);
  - `step_spikes` = 4'b0001 in step 3;
  - `done` at cycle 85, `winner` = 0, `no_spike` = 0.
- Currents {0,0,0,0}: no `step_spikes` bit ever set; `done` at cycle 85 with `no_spike` = 1 and `winner` = 0.
- Currents {0,0,150,150}:
  - both spike first at step 2 and `step_spikes` = 4'b1100;
  - INHIBIT clears mem[3] and keeps mem[2] = 25;
  - final counts tie or favour neuron 2 → `winner` = 2.
- Currents {255,255,255,255}: membranes saturate at 255 with no 9-bit wrap, and every neuron spikes each step; all counts equal (16) → `winner` = 0.
- Handshake: `cur_valid` low for 3 cycles between transfers 1 and 2 → `cur_ready` is held and there is no extra load. A `start` pulse mid-UPDATE is ignored.
- `rst_n` pulsed low asynchronously mid-UPDATE:
  - `busy` = 0 immediately and there is no `done`;
  - a new `start` with {120,0,0,0} reproduces scenario 1 exactly.
